// File: rtl/vx_issue_pkg.sv
// Shared widths, execute-unit encodings and the decoded-instruction record for the issue stage.
package vx_issue_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int NUM_REGS    = 64;
    localparam int XLEN        = 32;
    localparam int PERF_W      = 44;

    localparam int WID_W  = $clog2(NUM_WARPS);
    localparam int REG_W  = $clog2(NUM_REGS);
    localparam int DATA_W = NUM_THREADS * XLEN;

    localparam logic [2:0] EX_ALU = 3'd0;
    localparam logic [2:0] EX_LSU = 3'd1;
    localparam logic [2:0] EX_CSR = 3'd2;
    localparam logic [2:0] EX_FPU = 3'd3;
    localparam logic [2:0] EX_GPU = 3'd4;

    // Everything the execute side needs; rs2/rs3 only address the register file, so they are not kept.
    typedef struct packed {
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [XLEN-1:0]        pc;
        logic [2:0]             ex_type;
        logic [3:0]             op_type;
        logic [2:0]             op_mod;
        logic                   wb;
        logic [REG_W-1:0]       rd;
        logic [REG_W-1:0]       rs1;
        logic [XLEN-1:0]        imm;
        logic                   use_pc;
        logic                   use_imm;
    } issue_instr_t;

    function automatic logic [PERF_W-1:0] active_lanes(input logic [NUM_THREADS-1:0] mask);
        logic [PERF_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cnt = cnt + PERF_W'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/vx_issue_scoreboard.sv
// Per-warp register busy bits with a combinational RAW/WAW hazard check against registered state.
module vx_issue_scoreboard
    import vx_issue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WID_W-1:0] chk_wid,
    input  logic [REG_W-1:0] chk_rs1,
    input  logic [REG_W-1:0] chk_rs2,
    input  logic [REG_W-1:0] chk_rs3,
    input  logic [REG_W-1:0] chk_rd,
    input  logic             chk_wb,
    input  logic             set_valid,
    input  logic [WID_W-1:0] set_wid,
    input  logic [REG_W-1:0] set_rd,
    input  logic             clr_valid,
    input  logic [WID_W-1:0] clr_wid,
    input  logic [REG_W-1:0] clr_rd,
    output logic             hazard
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_next;

    // Clear is applied first so a same-cycle set of the same entry wins; x0 is never tracked.
    always_comb begin
        busy_next = busy;
        if (clr_valid) begin
            busy_next[clr_wid][clr_rd] = 1'b0;
        end
        if (set_valid && (set_rd != '0)) begin
            busy_next[set_wid][set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign hazard = busy[chk_wid][chk_rs1]
                  | busy[chk_wid][chk_rs2]
                  | busy[chk_wid][chk_rs3]
                  | (chk_wb & busy[chk_wid][chk_rd]);

endmodule

// File: rtl/vx_issue_unit.sv
// Issue stage: scoreboard gating, GPR read request, output register with operand bypass/hold.
// Optional build macro PERF_COUNTERS_EN adds the four performance counters and their ports.
module vx_issue_unit
    import vx_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [WID_W-1:0]       dec_wid,
    input  logic [NUM_THREADS-1:0] dec_tmask,
    input  logic [XLEN-1:0]        dec_pc,
    input  logic [2:0]             dec_ex_type,
    input  logic [3:0]             dec_op_type,
    input  logic [2:0]             dec_op_mod,
    input  logic                   dec_wb,
    input  logic [REG_W-1:0]       dec_rd,
    input  logic [REG_W-1:0]       dec_rs1,
    input  logic [REG_W-1:0]       dec_rs2,
    input  logic [REG_W-1:0]       dec_rs3,
    input  logic [XLEN-1:0]        dec_imm,
    input  logic                   dec_use_pc,
    input  logic                   dec_use_imm,

    output logic [WID_W-1:0]       gpr_req_wid,
    output logic [REG_W-1:0]       gpr_req_rs1,
    output logic [REG_W-1:0]       gpr_req_rs2,
    output logic [REG_W-1:0]       gpr_req_rs3,
    input  logic [DATA_W-1:0]      gpr_rsp_rs1_data,
    input  logic [DATA_W-1:0]      gpr_rsp_rs2_data,
    input  logic [DATA_W-1:0]      gpr_rsp_rs3_data,

    input  logic                   wb_valid,
    input  logic [WID_W-1:0]       wb_wid,
    input  logic [REG_W-1:0]       wb_rd,
    input  logic                   wb_eop,

    output logic                   iss_valid,
    input  logic                   iss_ready,
    output logic [WID_W-1:0]       iss_wid,
    output logic [NUM_THREADS-1:0] iss_tmask,
    output logic [XLEN-1:0]        iss_pc,
    output logic [2:0]             iss_ex_type,
    output logic [3:0]             iss_op_type,
    output logic [2:0]             iss_op_mod,
    output logic                   iss_wb,
    output logic [REG_W-1:0]       iss_rd,
    output logic [REG_W-1:0]       iss_rs1,
    output logic [XLEN-1:0]        iss_imm,
    output logic                   iss_use_pc,
    output logic                   iss_use_imm,
    output logic [DATA_W-1:0]      iss_rs1_data,
    output logic [DATA_W-1:0]      iss_rs2_data,
    output logic [DATA_W-1:0]      iss_rs3_data
`ifdef PERF_COUNTERS_EN
    ,
    output logic [PERF_W-1:0]      perf_scb_stalls,
    output logic [PERF_W-1:0]      perf_iss_stalls,
    output logic [PERF_W-1:0]      perf_issued,
    output logic [PERF_W-1:0]      perf_active_thr
`endif
);

    issue_instr_t dec_instr;
    issue_instr_t iss_instr;
    logic         hazard;
    logic         scb_stall;
    logic         fire;
    logic         first_cycle;
    logic [DATA_W-1:0] hold_rs1;
    logic [DATA_W-1:0] hold_rs2;
    logic [DATA_W-1:0] hold_rs3;

    assign dec_instr = '{
        wid:     dec_wid,
        tmask:   dec_tmask,
        pc:      dec_pc,
        ex_type: dec_ex_type,
        op_type: dec_op_type,
        op_mod:  dec_op_mod,
        wb:      dec_wb,
        rd:      dec_rd,
        rs1:     dec_rs1,
        imm:     dec_imm,
        use_pc:  dec_use_pc,
        use_imm: dec_use_imm
    };

    assign gpr_req_wid = dec_wid;
    assign gpr_req_rs1 = dec_rs1;
    assign gpr_req_rs2 = dec_rs2;
    assign gpr_req_rs3 = dec_rs3;

    vx_issue_scoreboard scoreboard (
        .clk       (clk),
        .reset     (reset),
        .chk_wid   (dec_wid),
        .chk_rs1   (dec_rs1),
        .chk_rs2   (dec_rs2),
        .chk_rs3   (dec_rs3),
        .chk_rd    (dec_rd),
        .chk_wb    (dec_wb),
        .set_valid (fire & dec_wb),
        .set_wid   (dec_wid),
        .set_rd    (dec_rd),
        .clr_valid (wb_valid & wb_eop),
        .clr_wid   (wb_wid),
        .clr_rd    (wb_rd),
        .hazard    (hazard)
    );

    assign scb_stall = dec_valid & hazard;
    assign dec_ready = ~scb_stall & (~iss_valid | iss_ready);
    assign fire      = dec_valid & dec_ready;

    // first_cycle marks the cycle where the GPR response for the held instruction is on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid   <= 1'b0;
            iss_instr   <= '0;
            first_cycle <= 1'b0;
        end else begin
            if (fire) begin
                iss_valid <= 1'b1;
                iss_instr <= dec_instr;
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
            first_cycle <= fire;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_rs1 <= '0;
            hold_rs2 <= '0;
            hold_rs3 <= '0;
        end else if (first_cycle && !iss_ready) begin
            hold_rs1 <= gpr_rsp_rs1_data;
            hold_rs2 <= gpr_rsp_rs2_data;
            hold_rs3 <= gpr_rsp_rs3_data;
        end
    end

    assign iss_rs1_data = first_cycle ? gpr_rsp_rs1_data : hold_rs1;
    assign iss_rs2_data = first_cycle ? gpr_rsp_rs2_data : hold_rs2;
    assign iss_rs3_data = first_cycle ? gpr_rsp_rs3_data : hold_rs3;

    assign iss_wid     = iss_instr.wid;
    assign iss_tmask   = iss_instr.tmask;
    assign iss_pc      = iss_instr.pc;
    assign iss_ex_type = iss_instr.ex_type;
    assign iss_op_type = iss_instr.op_type;
    assign iss_op_mod  = iss_instr.op_mod;
    assign iss_wb      = iss_instr.wb;
    assign iss_rd      = iss_instr.rd;
    assign iss_rs1     = iss_instr.rs1;
    assign iss_imm     = iss_instr.imm;
    assign iss_use_pc  = iss_instr.use_pc;
    assign iss_use_imm = iss_instr.use_imm;

`ifdef PERF_COUNTERS_EN
    // Counters wrap naturally at PERF_W bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_scb_stalls <= '0;
            perf_iss_stalls <= '0;
            perf_issued     <= '0;
            perf_active_thr <= '0;
        end else begin
            if (scb_stall) begin
                perf_scb_stalls <= perf_scb_stalls + 1'b1;
            end
            if (iss_valid && !iss_ready) begin
                perf_iss_stalls <= perf_iss_stalls + 1'b1;
            end
            if (fire) begin
                perf_issued     <= perf_issued + 1'b1;
                perf_active_thr <= perf_active_thr + active_lanes(dec_tmask);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_issue_unit.sv
// Bench for vx_issue_unit: directed vector table, hand-written corner sequences and a random run
// checked against a rule-level reference model. Honours PERF_COUNTERS_EN like the design.
module tb_vx_issue_unit;
    import vx_issue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic                   dec_valid;
    logic                   dec_ready;
    logic [WID_W-1:0]       dec_wid;
    logic [NUM_THREADS-1:0] dec_tmask;
    logic [XLEN-1:0]        dec_pc;
    logic [2:0]             dec_ex_type;
    logic [3:0]             dec_op_type;
    logic [2:0]             dec_op_mod;
    logic                   dec_wb;
    logic [REG_W-1:0]       dec_rd, dec_rs1, dec_rs2, dec_rs3;
    logic [XLEN-1:0]        dec_imm;
    logic                   dec_use_pc, dec_use_imm;
    logic [WID_W-1:0]       gpr_req_wid;
    logic [REG_W-1:0]       gpr_req_rs1, gpr_req_rs2, gpr_req_rs3;
    logic [DATA_W-1:0]      gpr_rsp_rs1_data, gpr_rsp_rs2_data, gpr_rsp_rs3_data;
    logic                   wb_valid;
    logic [WID_W-1:0]       wb_wid;
    logic [REG_W-1:0]       wb_rd;
    logic                   wb_eop;
    logic                   iss_valid, iss_ready;
    logic [WID_W-1:0]       iss_wid;
    logic [NUM_THREADS-1:0] iss_tmask;
    logic [XLEN-1:0]        iss_pc;
    logic [2:0]             iss_ex_type;
    logic [3:0]             iss_op_type;
    logic [2:0]             iss_op_mod;
    logic                   iss_wb;
    logic [REG_W-1:0]       iss_rd, iss_rs1;
    logic [XLEN-1:0]        iss_imm;
    logic                   iss_use_pc, iss_use_imm;
    logic [DATA_W-1:0]      iss_rs1_data, iss_rs2_data, iss_rs3_data;
`ifdef PERF_COUNTERS_EN
    logic [PERF_W-1:0]      perf_scb_stalls, perf_iss_stalls, perf_issued, perf_active_thr;
`endif

    vx_issue_unit dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_wid(dec_wid), .dec_tmask(dec_tmask),
        .dec_pc(dec_pc), .dec_ex_type(dec_ex_type), .dec_op_type(dec_op_type), .dec_op_mod(dec_op_mod),
        .dec_wb(dec_wb), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
        .dec_imm(dec_imm), .dec_use_pc(dec_use_pc), .dec_use_imm(dec_use_imm),
        .gpr_req_wid(gpr_req_wid), .gpr_req_rs1(gpr_req_rs1), .gpr_req_rs2(gpr_req_rs2),
        .gpr_req_rs3(gpr_req_rs3),
        .gpr_rsp_rs1_data(gpr_rsp_rs1_data), .gpr_rsp_rs2_data(gpr_rsp_rs2_data),
        .gpr_rsp_rs3_data(gpr_rsp_rs3_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_wid(iss_wid), .iss_tmask(iss_tmask),
        .iss_pc(iss_pc), .iss_ex_type(iss_ex_type), .iss_op_type(iss_op_type), .iss_op_mod(iss_op_mod),
        .iss_wb(iss_wb), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_imm(iss_imm),
        .iss_use_pc(iss_use_pc), .iss_use_imm(iss_use_imm),
        .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data), .iss_rs3_data(iss_rs3_data)
`ifdef PERF_COUNTERS_EN
        ,
        .perf_scb_stalls(perf_scb_stalls), .perf_iss_stalls(perf_iss_stalls),
        .perf_issued(perf_issued), .perf_active_thr(perf_active_thr)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the execute side should be holding, and which registers are pending.
    bit           m_busy [NUM_WARPS][NUM_REGS];
    bit           m_valid;
    issue_instr_t m_instr;
    bit           m_fresh;
    logic [DATA_W-1:0] m_frozen [3];
    longint unsigned m_scb, m_iss, m_issued, m_thr;

    typedef struct {
        bit dv; int wid; int rs1; int rd; bit wb; bit rdy; bit wbv; int wbrd;
        bit exp_ready; bit exp_valid;
    } vec_t;
    vec_t vt [18];

    task automatic checkVal(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic issue_instr_t curDec();
        return '{wid: dec_wid, tmask: dec_tmask, pc: dec_pc, ex_type: dec_ex_type,
                 op_type: dec_op_type, op_mod: dec_op_mod, wb: dec_wb, rd: dec_rd, rs1: dec_rs1,
                 imm: dec_imm, use_pc: dec_use_pc, use_imm: dec_use_imm};
    endfunction

    function automatic issue_instr_t dutIss();
        return '{wid: iss_wid, tmask: iss_tmask, pc: iss_pc, ex_type: iss_ex_type,
                 op_type: iss_op_type, op_mod: iss_op_mod, wb: iss_wb, rd: iss_rd, rs1: iss_rs1,
                 imm: iss_imm, use_pc: iss_use_pc, use_imm: iss_use_imm};
    endfunction

    function automatic bit modelReady();
        bit haz;
        haz = m_busy[dec_wid][dec_rs1] || m_busy[dec_wid][dec_rs2] || m_busy[dec_wid][dec_rs3]
              || (dec_wb && m_busy[dec_wid][dec_rd]);
        return !(dec_valid && haz) && (!m_valid || iss_ready);
    endfunction

    task automatic modelReset();
        foreach (m_busy[w, r]) m_busy[w][r] = 1'b0;
        m_valid = 1'b0; m_instr = '0; m_fresh = 1'b0;
        m_scb = 0; m_iss = 0; m_issued = 0; m_thr = 0;
    endtask

    task automatic checkOutput();
        #1;
        if (!reset) begin
            checkVal("dec_ready", DATA_W'(dec_ready), DATA_W'(modelReady()));
            checkVal("gpr_req", DATA_W'({gpr_req_wid, gpr_req_rs1, gpr_req_rs2, gpr_req_rs3}),
                     DATA_W'({dec_wid, dec_rs1, dec_rs2, dec_rs3}));
            checkVal("iss_valid", DATA_W'(iss_valid), DATA_W'(m_valid));
            checkVal("iss_fields", DATA_W'(dutIss()), DATA_W'(m_instr));
            if (m_valid) begin
                checkVal("iss_rs1_data", iss_rs1_data, m_fresh ? gpr_rsp_rs1_data : m_frozen[0]);
                checkVal("iss_rs2_data", iss_rs2_data, m_fresh ? gpr_rsp_rs2_data : m_frozen[1]);
                checkVal("iss_rs3_data", iss_rs3_data, m_fresh ? gpr_rsp_rs3_data : m_frozen[2]);
            end
`ifdef PERF_COUNTERS_EN
            checkVal("perf_scb_stalls", DATA_W'(perf_scb_stalls), DATA_W'(PERF_W'(m_scb)));
            checkVal("perf_iss_stalls", DATA_W'(perf_iss_stalls), DATA_W'(PERF_W'(m_iss)));
            checkVal("perf_issued", DATA_W'(perf_issued), DATA_W'(PERF_W'(m_issued)));
            checkVal("perf_active_thr", DATA_W'(perf_active_thr), DATA_W'(PERF_W'(m_thr)));
`endif
        end
    endtask

    // Advance one clock, moving the model forward with the inputs the DUT samples on this edge.
    task automatic advance();
        bit f;
        if (reset) begin
            modelReset();
        end else begin
            f = dec_valid && modelReady();
            if (dec_valid && !modelReady() && !(m_valid && !iss_ready)) m_scb++;
            else if (dec_valid && (m_busy[dec_wid][dec_rs1] || m_busy[dec_wid][dec_rs2] ||
                     m_busy[dec_wid][dec_rs3] || (dec_wb && m_busy[dec_wid][dec_rd]))) m_scb++;
            if (m_valid && !iss_ready) m_iss++;
            if (f) begin m_issued++; m_thr += $countones(dec_tmask); end
            if (m_valid && m_fresh && !iss_ready) begin
                m_frozen[0] = gpr_rsp_rs1_data;
                m_frozen[1] = gpr_rsp_rs2_data;
                m_frozen[2] = gpr_rsp_rs3_data;
            end
            if (wb_valid && wb_eop) m_busy[wb_wid][wb_rd] = 1'b0;
            if (f && dec_wb && dec_rd != 0) m_busy[dec_wid][dec_rd] = 1'b1;
            if (f) begin m_valid = 1'b1; m_instr = curDec(); end
            else if (iss_ready) m_valid = 1'b0;
            m_fresh = f;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setDec(input bit dv, input int wid, input int rs1, input int rd, input bit wb,
                          input bit rdy);
        logic [2:0] ex_sel [5];
        ex_sel = '{EX_ALU, EX_LSU, EX_CSR, EX_FPU, EX_GPU};
        dec_valid = dv; dec_wid = WID_W'(wid); dec_rs1 = REG_W'(rs1); dec_rd = REG_W'(rd);
        dec_wb = wb; dec_rs2 = '0; dec_rs3 = '0; iss_ready = rdy;
        dec_tmask = NUM_THREADS'($urandom); dec_pc = $urandom; dec_imm = $urandom;
        dec_ex_type = ex_sel[$urandom_range(0, 4)]; dec_op_type = 4'($urandom);
        dec_op_mod = 3'($urandom); dec_use_pc = 1'($urandom); dec_use_imm = 1'($urandom);
        wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_eop = 1'b1;
        gpr_rsp_rs1_data = {$urandom, $urandom, $urandom, $urandom};
        gpr_rsp_rs2_data = {$urandom, $urandom, $urandom, $urandom};
        gpr_rsp_rs3_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic applyStimulus(input vec_t v);
        setDec(v.dv, v.wid, v.rs1, v.rd, v.wb, v.rdy);
        wb_valid = v.wbv; wb_wid = '0; wb_rd = REG_W'(v.wbrd);
    endtask

    task automatic doReset();
        setDec(1'b0, 0, 0, 0, 1'b0, 1'b1);
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        setDec(1'b0, 0, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        doReset();

        checkOutput();
        checkVal("reset_ready", DATA_W'(dec_ready), DATA_W'(1));
        checkVal("reset_valid", DATA_W'(iss_valid), DATA_W'(0));
        checkVal("reset_fields", DATA_W'(dutIss()), DATA_W'(0));

        //       dv wid rs1 rd wb rdy wbv wbrd  ready valid
        vt[0]  = '{1, 0, 0, 5, 1, 1, 0, 0, 1, 0};
        vt[1]  = '{1, 0, 5, 0, 0, 1, 0, 0, 0, 1};
        vt[2]  = '{1, 0, 5, 0, 0, 1, 1, 5, 0, 0};
        vt[3]  = '{1, 0, 5, 0, 0, 1, 0, 0, 1, 0};
        vt[4]  = '{1, 0, 0, 5, 1, 1, 0, 0, 1, 1};
        vt[5]  = '{1, 1, 5, 0, 0, 1, 0, 0, 1, 1};
        vt[6]  = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 1};
        vt[7]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 1};
        vt[8]  = '{1, 0, 5, 0, 0, 1, 0, 0, 0, 1};
        vt[9]  = '{1, 0, 0, 5, 1, 1, 1, 5, 0, 0};
        vt[10] = '{1, 0, 0, 5, 1, 1, 0, 0, 1, 0};
        vt[11] = '{0, 0, 0, 0, 0, 1, 1, 5, 1, 1};
        vt[12] = '{1, 0, 5, 0, 0, 1, 0, 0, 1, 0};
        vt[13] = '{1, 0, 0, 7, 1, 1, 1, 7, 1, 1};
        vt[14] = '{1, 0, 7, 0, 0, 1, 0, 0, 0, 1};
        vt[15] = '{1, 2, 0, 0, 0, 0, 0, 0, 1, 0};
        vt[16] = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[17] = '{1, 2, 0, 0, 0, 1, 0, 0, 1, 1};
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vt[i]);
            checkOutput();
            checkVal($sformatf("vec%0d_ready", i), DATA_W'(dec_ready), DATA_W'(vt[i].exp_ready));
            checkVal($sformatf("vec%0d_valid", i), DATA_W'(iss_valid), DATA_W'(vt[i].exp_valid));
            advance();
        end

        // Operand hold: data captured on the first valid cycle survives a 3-cycle stall.
        doReset();
        setDec(1, 1, 2, 3, 1, 0); checkOutput(); advance();
        for (int c = 0; c < 4; c++) begin
            setDec(1, 2, 1, 0, 0, c == 3);
            if (c == 0) gpr_rsp_rs1_data = {4{32'hA5A5_0000}};
            checkOutput();
            checkVal($sformatf("hold%0d_data", c), iss_rs1_data, {4{32'hA5A5_0000}});
            checkVal($sformatf("hold%0d_ready", c), DATA_W'(dec_ready), DATA_W'(c == 3));
            advance();
        end

        // Reset while an instruction is held and rd9 is pending.
        doReset();
        setDec(1, 0, 0, 9, 1, 0); checkOutput(); advance();
        setDec(0, 0, 0, 0, 0, 0); checkOutput();
        checkVal("pre_reset_valid", DATA_W'(iss_valid), DATA_W'(1));
        reset = 1'b1; advance(); reset = 1'b0;
        setDec(1, 0, 9, 0, 0, 1); checkOutput();
        checkVal("post_reset_valid", DATA_W'(iss_valid), DATA_W'(0));
        checkVal("post_reset_ready", DATA_W'(dec_ready), DATA_W'(1));
        advance();

        // Back-to-back stream of ten instructions.
        doReset();
        for (int i = 0; i < 10; i++) begin
            setDec(1, i % NUM_WARPS, 0, 0, 0, 1);
            dec_tmask = 4'b1011;
            checkOutput();
            checkVal($sformatf("stream%0d_ready", i), DATA_W'(dec_ready), DATA_W'(1));
            checkVal($sformatf("stream%0d_valid", i), DATA_W'(iss_valid), DATA_W'(i != 0));
            advance();
        end
        setDec(0, 0, 0, 0, 0, 1); checkOutput();
`ifdef PERF_COUNTERS_EN
        checkVal("stream_issued", DATA_W'(perf_issued), DATA_W'(10));
        checkVal("stream_active_thr", DATA_W'(perf_active_thr), DATA_W'(30));
`endif
        advance();

        // Random traffic against the model, with occasional mid-run resets.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            setDec($urandom_range(0, 9) < 7, $urandom_range(0, NUM_WARPS - 1), $urandom_range(0, 7),
                   $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 9) < 6);
            dec_rs2 = REG_W'($urandom_range(0, 7));
            dec_rs3 = REG_W'($urandom_range(0, 7));
            wb_valid = $urandom_range(0, 1) == 1;
            wb_wid = WID_W'($urandom_range(0, NUM_WARPS - 1));
            wb_rd = REG_W'($urandom_range(0, 7));
            wb_eop = $urandom_range(0, 4) != 0;
            reset = $urandom_range(0, 299) == 0;
            checkOutput();
            advance();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
